// File: rtl/bch_encode_stream.sv
// Purpose : streaming systematic BCH encoder; message beats pass through, then R/BITS parity beats follow.
// Latency : 1 cycle from an accepted input beat to the same bits on m_data.
// Backpres: single registered output stage; s_ready drops while it is full and m_ready is low, and during parity beats.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   s_valid/s_ready/s_first    input beat handshake; s_first marks the first message beat
//   s_data[BITS-1:0]           message bits, bit BITS-1 is the highest-order coefficient (sent first)
//   m_valid/m_ready            output beat handshake
//   m_data[BITS-1:0]           codeword bits, same order as s_data
//   m_first/m_last/m_parity    first codeword beat, last codeword beat, beat carries parity bits
module bch_encode_stream #(
  parameter int                  DATA_BITS = 7,
  parameter int                  ECC_BITS  = 8,
  parameter logic [ECC_BITS-1:0] GEN_POLY  = 8'hD1,
  parameter int                  BITS      = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic            s_first,
  input  logic [BITS-1:0] s_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [BITS-1:0] m_data,
  output logic            m_first,
  output logic            m_last,
  output logic            m_parity
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  localparam int DATA_BEATS = DATA_BITS / BITS;
  localparam int ECC_BEATS  = ECC_BITS / BITS;
  localparam int MAX_BEATS  = (DATA_BEATS > ECC_BEATS) ? DATA_BEATS : ECC_BEATS;
  localparam int CNT_W      = $clog2(MAX_BEATS + 1);

  localparam logic [CNT_W-1:0] LAST_DATA_CNT = CNT_W'(DATA_BEATS - 1);
  localparam logic [CNT_W-1:0] LAST_PAR_CNT  = CNT_W'(ECC_BEATS - 1);

  state_t              state;
  logic [ECC_BITS-1:0] lfsr;
  logic [CNT_W-1:0]    cnt;

  logic                out_free;
  logic                accept;
  logic                restart;
  logic [ECC_BITS-1:0] lfsr_next;

  // BITS steps of polynomial division by g(x), MSB of the beat first.
  function automatic logic [ECC_BITS-1:0] lfsr_step(input logic [ECC_BITS-1:0] l,
                                                    input logic [BITS-1:0]     d);
    logic [ECC_BITS-1:0] r;
    logic                fb;
    r = l;
    for (int i = BITS - 1; i >= 0; i--) begin
      fb = d[i] ^ r[ECC_BITS-1];
      r  = (r << 1) ^ (fb ? GEN_POLY : '0);
    end
    return r;
  endfunction

  assign out_free = !m_valid || m_ready;
  // Gated by rst_n so the input is never offered acceptance while reset is held.
  assign s_ready  = rst_n && (state != PARITY) && out_free;
  assign accept   = s_valid && s_ready;

  // A beat in IDLE always opens a codeword; s_first in DATA aborts and reopens.
  assign restart   = (state == IDLE) || s_first;
  assign lfsr_next = lfsr_step(restart ? '0 : lfsr, s_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lfsr     <= '0;
      cnt      <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_first  <= 1'b0;
      m_last   <= 1'b0;
      m_parity <= 1'b0;
    end else begin
      case (state)
        IDLE, DATA: begin
          if (accept) begin
            lfsr     <= lfsr_next;
            m_valid  <= 1'b1;
            m_data   <= s_data;
            m_parity <= 1'b0;
            m_last   <= 1'b0;
            if (restart) begin
              m_first <= 1'b1;
              if (DATA_BEATS == 1) begin
                state <= PARITY;
                cnt   <= '0;
              end else begin
                state <= DATA;
                cnt   <= CNT_W'(1);
              end
            end else begin
              m_first <= 1'b0;
              if (cnt == LAST_DATA_CNT) begin
                state <= PARITY;
                cnt   <= '0;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end else if (out_free) begin
            m_valid <= 1'b0;
          end
        end

        PARITY: begin
          // Output stage is the only gate here; a stalled sink freezes the LFSR.
          if (out_free) begin
            m_valid  <= 1'b1;
            m_data   <= lfsr[ECC_BITS-1 -: BITS];
            m_first  <= 1'b0;
            m_parity <= 1'b1;
            lfsr     <= lfsr << BITS;
            if (cnt == LAST_PAR_CNT) begin
              m_last <= 1'b1;
              state  <= IDLE;
              cnt    <= '0;
            end else begin
              m_last <= 1'b0;
              cnt    <= cnt + CNT_W'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bch_encode_stream.md
BCH_ENCODE_STREAM -- requirements
Module: bch_encode_stream

Interface
REQ-001 SHALL have parameter DATA_BITS, default 7: message bits per codeword; must be a multiple of BITS.
REQ-002 SHALL have parameter ECC_BITS, default 8: parity bits R = deg g(x); must be a multiple of BITS.
REQ-003 SHALL have parameter GEN_POLY, default 8'hD1: low R coefficients of g(x); the x^R term is implicit.
REQ-004 SHALL have parameter BITS, default 1: bits per beat.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 SHALL have port s_valid, input, 1 bit: an input beat is offered.
REQ-008 SHALL have port s_ready, output, 1 bit: the input beat is accepted when s_valid and s_ready are both high.
REQ-009 SHALL have port s_first, input, 1 bit: the offered beat is the first message beat of a codeword.
REQ-010 SHALL have port s_data, input, BITS bits: message bits; bit BITS-1 is the highest-order coefficient and is sent first.
REQ-011 SHALL have port m_valid, output, 1 bit: an output beat is present.
REQ-012 SHALL have port m_ready, input, 1 bit: the output beat is consumed when m_valid and m_ready are both high.
REQ-013 SHALL have port m_data, output, BITS bits: codeword bits, same bit order as s_data.
REQ-014 SHALL have ports m_first, m_last and m_parity, outputs, 1 bit each: first codeword beat, last codeword beat, beat carries parity bits.

Function
REQ-015 SHALL output the systematic codeword c(x) = d(x)*x^R + (d(x)*x^R mod g(x)): message beats unchanged, then R/BITS parity beats.
REQ-016 SHALL use a 3-state FSM: IDLE, DATA, PARITY.
REQ-017 SHALL keep a beat counter sized for max(DATA_BITS, ECC_BITS)/BITS.
REQ-018 SHALL hold a registered output stage; "load" means the output register is free (!m_valid || m_ready) on a cycle where new content is available.
REQ-019 SHALL drive s_ready = (state is IDLE or DATA) && output register free.
REQ-020 SHALL, on each accepted beat, update the R-bit LFSR by BITS steps of division by g(x) in one cycle, and load s_data into m_data with m_parity=0.
REQ-021 SHALL give message beats a latency of 1: a beat accepted at edge t is on m_data after edge t.
REQ-022 SHALL, in IDLE, treat any accepted beat as the first beat: clear the LFSR before the update, set m_first=1, set counter=1, and go to DATA, or straight to PARITY if DATA_BITS==BITS. s_first is ignored in IDLE.
REQ-023 SHALL, in DATA, move to PARITY when the beat accepted is number DATA_BITS/BITS, and clear the counter.
REQ-024 SHALL, in DATA, treat an accepted beat with s_first=1 as an abort and restart: the LFSR restarts from this beat, m_first=1, counter=1, and no m_last is produced for the aborted codeword.
REQ-025 SHALL, in PARITY, on each free output cycle, load lfsr[R-1 -: BITS] with m_parity=1, shift the LFSR left by BITS, and increment the counter.
REQ-026 SHALL assert m_last on the parity beat numbered R/BITS and return to IDLE on the same edge.
REQ-027 SHALL sustain output with no gap between codewords when m_ready is held high; the input stalls for exactly R/BITS cycles per codeword.
REQ-028 SHALL keep m_data, m_first, m_last and m_parity stable while m_valid && !m_ready, and SHALL not advance the LFSR during that time.
REQ-029 SHALL make all status flags qualified by m_valid; they are don't-care when m_valid=0.

Reset
REQ-030 SHALL, while rst_n=0, set state=IDLE, LFSR=0, counter=0, and all m_* outputs and s_ready to 0.
REQ-031 SHALL drive s_ready=1 on the first cycle after rst_n deasserts.
REQ-032 SHALL, on reset during a codeword, discard it entirely; the next accepted beat starts a new codeword.

Verification (BCH(15,7), defaults, BITS=1, m_ready=1 unless stated)
REQ-033 SHALL be checked: message 0000000 -> m_data 000000000000000 over 15 consecutive beats; m_first on beat 1, m_parity on beats 8-15, m_last on beat 15.
REQ-034 SHALL be checked: message 0000001 -> parity beats 1,1,0,1,0,0,0,1 (0xD1).
REQ-035 SHALL be checked: message 1111111 -> parity 11111111.
REQ-036 SHALL be checked: random m_ready backpressure over 1000 random codewords -> output matches a reference model and no beat is dropped or duplicated.
REQ-037 SHALL be checked: s_first reasserted at message beat 4 -> the next 15 beats form a valid codeword of the restarted message, with no m_last before it.
REQ-038 SHALL be checked: rst_n pulsed during a parity beat -> m_valid=0 immediately, and the next codeword output is correct.
